// File: rtl/multicycle_ctrl_pkg.sv
// ============================================================================
// multicycle_ctrl_pkg
// Shared encodings for the multicycle controller: states, instruction
// classes, immediate formats, opcodes and datapath select codes.
// Revision: 1.0
// ============================================================================
`default_nettype none

package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JAL    = 3'd4,
        CLS_JALR   = 3'd5,
        CLS_AUIPC  = 3'd6
    } cls_e;

    localparam logic [2:0] c_FMT_R  = 3'd0;
    localparam logic [2:0] c_FMT_I  = 3'd1;
    localparam logic [2:0] c_FMT_S  = 3'd2;
    localparam logic [2:0] c_FMT_SB = 3'd3;
    localparam logic [2:0] c_FMT_U  = 3'd4;
    localparam logic [2:0] c_FMT_UJ = 3'd5;

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;

    localparam logic [1:0] c_PC_SEL_PLUS4  = 2'd0;
    localparam logic [1:0] c_PC_SEL_TARGET = 2'd1;
    localparam logic [1:0] c_PC_SEL_JALR   = 2'd2;

    localparam logic [1:0] c_WB_SEL_ALU = 2'd0;
    localparam logic [1:0] c_WB_SEL_MEM = 2'd1;
    localparam logic [1:0] c_WB_SEL_PC4 = 2'd2;

    function automatic logic fmt_sign_ext(input logic [2:0] fmt);
        return (fmt == c_FMT_I) || (fmt == c_FMT_S) || (fmt == c_FMT_SB);
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_opcode_classify.sv
// ============================================================================
// multicycle_ctrl_opcode_classify
// Combinational opcode decode into immediate format, class and illegal flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl_opcode_classify
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic [2:0] fmt_o,
    output logic [2:0] cls_o,
    output logic       illegal_o
);

    always_comb begin
        fmt_o     = c_FMT_R;
        cls_o     = CLS_ALU;
        illegal_o = 1'b0;
        case (opcode_i)
            c_OPC_OP:     fmt_o = c_FMT_R;
            c_OPC_OP_IMM: fmt_o = c_FMT_I;
            c_OPC_LOAD:   begin fmt_o = c_FMT_I;  cls_o = CLS_LOAD;   end
            c_OPC_JALR:   begin fmt_o = c_FMT_I;  cls_o = CLS_JALR;   end
            c_OPC_STORE:  begin fmt_o = c_FMT_S;  cls_o = CLS_STORE;  end
            c_OPC_BRANCH: begin fmt_o = c_FMT_SB; cls_o = CLS_BRANCH; end
            c_OPC_LUI:    fmt_o = c_FMT_U;
            c_OPC_AUIPC:  begin fmt_o = c_FMT_U;  cls_o = CLS_AUIPC;  end
            c_OPC_JAL:    begin fmt_o = c_FMT_UJ; cls_o = CLS_JAL;    end
            default:      illegal_o = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl
// FETCH/DECODE/EXEC/MEM/WB control FSM for a non-pipelined RV32I datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inst_i,
    input  logic             halt_i,
    input  logic             mem_ready_i,
    input  logic             branch_taken_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             mem_addr_sel_o,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic [1:0]       pc_sel_o,
    output logic             reg_we_o,
    output logic [1:0]       wb_sel_o,
    output logic             alu_src_a_o,
    output logic             alu_src_b_o,
    output logic [2:0]       inst_format_o,
    output logic             sign_ext_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instret_o
);

    state_e           state_q, state_d;
    cls_e             cls_q, cls_d;
    logic [2:0]       fmt_q, fmt_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [2:0] w_fmt;
    logic [2:0] w_cls;
    logic       w_illegal;
    logic       unused_inst;

    assign unused_inst = ^inst_i[31:7];

    multicycle_ctrl_opcode_classify u_classify (
        .opcode_i  (inst_i[6:0]),
        .fmt_o     (w_fmt),
        .cls_o     (w_cls),
        .illegal_o (w_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            cls_q     <= CLS_ALU;
            fmt_q     <= c_FMT_R;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            fmt_q     <= fmt_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cls_d          = cls_q;
        fmt_d          = fmt_q;
        illegal_d      = illegal_q;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_sel_o = 1'b0;
        ir_we_o        = 1'b0;
        pc_we_o        = 1'b0;
        pc_sel_o       = c_PC_SEL_PLUS4;
        reg_we_o       = 1'b0;
        wb_sel_o       = c_WB_SEL_ALU;
        alu_src_a_o    = 1'b0;
        alu_src_b_o    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                // rst_n gating makes the fetch request drop the instant reset asserts
                if (rst_n && !halt_i) begin
                    mem_req_o = 1'b1;
                    if (mem_ready_i) begin
                        ir_we_o = 1'b1;
                        state_d = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                if (w_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = ST_TRAP;
                end else begin
                    fmt_d   = w_fmt;
                    cls_d   = cls_e'(w_cls);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_src_b_o = (fmt_q != c_FMT_R) && (fmt_q != c_FMT_SB);
                alu_src_a_o = (cls_q == CLS_AUIPC) || (cls_q == CLS_JAL);
                case (cls_q)
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    CLS_BRANCH: begin
                        pc_we_o  = 1'b1;
                        pc_sel_o = branch_taken_i ? c_PC_SEL_TARGET : c_PC_SEL_PLUS4;
                        state_d  = ST_FETCH;
                    end
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                mem_req_o      = 1'b1;
                mem_addr_sel_o = 1'b1;
                mem_we_o       = (cls_q == CLS_STORE);
                if (mem_ready_i) begin
                    if (cls_q == CLS_STORE) begin
                        pc_we_o = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_we_o = 1'b1;
                pc_we_o  = 1'b1;
                case (cls_q)
                    CLS_LOAD: wb_sel_o = c_WB_SEL_MEM;
                    CLS_JAL:  begin wb_sel_o = c_WB_SEL_PC4; pc_sel_o = c_PC_SEL_TARGET; end
                    CLS_JALR: begin wb_sel_o = c_WB_SEL_PC4; pc_sel_o = c_PC_SEL_JALR;   end
                    default:  wb_sel_o = c_WB_SEL_ALU;
                endcase
                state_d = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
        instret_d = pc_we_o ? instret_q + CNT_W'(1) : instret_q;
    end

    assign inst_format_o = fmt_q;
    assign sign_ext_o    = fmt_sign_ext(fmt_q);
    assign illegal_o     = illegal_q;
    assign instret_o     = instret_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl
// Directed stimulus with hand-computed expectations for multicycle_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    localparam int CNT_W = 4;

    localparam logic [31:0] c_ADD  = 32'h002081B3;
    localparam logic [31:0] c_LW   = 32'h0000A183;
    localparam logic [31:0] c_BEQ  = 32'h00208463;
    localparam logic [31:0] c_SW   = 32'h0020A023;
    localparam logic [31:0] c_JAL  = 32'h008000EF;
    localparam logic [31:0] c_JALR = 32'h000080E7;
    localparam logic [31:0] c_BAD  = 32'h0000007F;

    logic             clk;
    logic             rst_n;
    logic [31:0]      inst;
    logic             halt, mem_ready, branch_taken;
    logic             mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we;
    logic [1:0]       pc_sel, wb_sel;
    logic             alu_src_a, alu_src_b, sign_ext, illegal;
    logic [2:0]       inst_format;
    logic [CNT_W-1:0] instret;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inst_i         (inst),
        .halt_i         (halt),
        .mem_ready_i    (mem_ready),
        .branch_taken_i (branch_taken),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_addr_sel_o (mem_addr_sel),
        .ir_we_o        (ir_we),
        .pc_we_o        (pc_we),
        .pc_sel_o       (pc_sel),
        .reg_we_o       (reg_we),
        .wb_sel_o       (wb_sel),
        .alu_src_a_o    (alu_src_a),
        .alu_src_b_o    (alu_src_b),
        .inst_format_o  (inst_format),
        .sign_ext_o     (sign_ext),
        .illegal_o      (illegal),
        .instret_o      (instret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, apply inputs, let outputs settle.
    task automatic cycle(input logic h, input logic mr, input logic bt);
        @(negedge clk);
        halt         = h;
        mem_ready    = mr;
        branch_taken = bt;
        #1;
    endtask

    task automatic fetch(input logic [31:0] ins, input logic [31:0] exp_ret);
        inst = ins;
        cycle(1'b0, 1'b1, 1'b0);
        check("fetch_mem_req", mem_req, 1);
        check("fetch_ir_we", ir_we, 1);
        check("fetch_addr_sel", mem_addr_sel, 0);
        check("fetch_instret", instret, exp_ret);
    endtask

    initial begin
        rst_n = 1'b0; inst = 32'h0; halt = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_illegal", illegal, 0);
        check("rst_instret", instret, 0);
        check("rst_fmt", inst_format, 0);
        check("rst_strobes", {ir_we, pc_we, reg_we, pc_sel, wb_sel}, 0);

        @(negedge clk);
        rst_n = 1'b1; halt = 1'b1;
        #1;
        check("halt_after_rst", mem_req, 0);

        // ADD: R-type, 4 cycles
        fetch(c_ADD, 0);
        cycle(1'b0, 1'b0, 1'b0);
        check("add_dec_strobes", {mem_req, ir_we, pc_we, reg_we}, 0);
        cycle(1'b0, 1'b0, 1'b0);
        check("add_fmt", inst_format, 0);
        check("add_srcs", {alu_src_a, alu_src_b, sign_ext}, 0);
        check("add_exec_pc_we", pc_we, 0);
        cycle(1'b0, 1'b0, 1'b0);
        check("add_wb_we", {reg_we, pc_we}, 2'b11);
        check("add_wb_sel", wb_sel, 0);
        check("add_pc_sel", pc_sel, 0);

        // LW with three memory wait cycles
        fetch(c_LW, 1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("lw_fmt", inst_format, 1);
        check("lw_sign_ext", sign_ext, 1);
        check("lw_srcs", {alu_src_a, alu_src_b}, 2'b01);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            check("lw_mem_wait", {mem_req, mem_we, mem_addr_sel, pc_we}, 4'b1010);
        end
        cycle(1'b0, 1'b1, 1'b0);
        check("lw_mem_done", {mem_req, mem_we, mem_addr_sel, pc_we, reg_we}, 5'b10100);
        cycle(1'b0, 1'b0, 1'b0);
        check("lw_wb_we", {reg_we, pc_we}, 2'b11);
        check("lw_wb_sel", wb_sel, 1);

        // BEQ taken then not taken
        fetch(c_BEQ, 2);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        check("beq_t_pc_we", pc_we, 1);
        check("beq_t_pc_sel", pc_sel, 1);
        check("beq_t_reg_we", reg_we, 0);
        check("beq_fmt", inst_format, 3);
        check("beq_sign_ext", sign_ext, 1);
        check("beq_src_b", alu_src_b, 0);
        fetch(c_BEQ, 3);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("beq_n_pc_we", pc_we, 1);
        check("beq_n_pc_sel", pc_sel, 0);
        check("beq_n_reg_we", reg_we, 0);

        // SW: retires from MEM
        fetch(c_SW, 4);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("sw_fmt", inst_format, 2);
        check("sw_exec", {mem_req, alu_src_b, pc_we}, 3'b010);
        cycle(1'b0, 1'b1, 1'b0);
        check("sw_mem", {mem_req, mem_we, mem_addr_sel, pc_we, reg_we}, 5'b11110);
        check("sw_pc_sel", pc_sel, 0);

        // JAL
        fetch(c_JAL, 5);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("jal_fmt", inst_format, 5);
        check("jal_srcs", {alu_src_a, alu_src_b, sign_ext}, 3'b110);
        cycle(1'b0, 1'b0, 1'b0);
        check("jal_wb", {reg_we, pc_we, wb_sel, pc_sel}, 6'b11_10_01);

        // halt in FETCH holds off the request and the state
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            check("halt_fetch", {mem_req, ir_we}, 0);
        end

        // JALR with halt asserted during EXEC/WB
        fetch(c_JALR, 6);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        check("jalr_fmt", inst_format, 1);
        check("jalr_srcs", {alu_src_a, alu_src_b}, 2'b01);
        cycle(1'b1, 1'b0, 1'b0);
        check("jalr_wb", {reg_we, pc_we, wb_sel, pc_sel}, 6'b11_10_10);

        // retire branches until the 4-bit counter wraps
        for (int k = 0; k < 9; k++) begin
            fetch(c_BEQ, (7 + k) % 16);
            cycle(1'b0, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, k[0]);
            check("wrap_pc_we", pc_we, 1);
        end

        // illegal opcode -> TRAP
        fetch(c_BAD, 0);
        cycle(1'b0, 1'b0, 1'b0);
        check("bad_dec_illegal", illegal, 0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, 1'b1);
            check("trap_illegal", illegal, 1);
            check("trap_strobes", {mem_req, mem_we, ir_we, pc_we, reg_we}, 0);
        end
        #2 rst_n = 1'b0;
        #1;
        check("trap_rst_illegal", illegal, 0);
        check("trap_rst_instret", instret, 0);
        check("trap_rst_fmt", inst_format, 0);
        @(negedge clk);
        rst_n = 1'b1; halt = 1'b0; mem_ready = 1'b0;
        #1;
        check("post_trap_fetch", {mem_req, mem_addr_sel}, 2'b10);

        // reset during a data-memory wait
        fetch(c_LW, 0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("mem_wait_req", {mem_req, mem_addr_sel}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("mem_rst_req", {mem_req, mem_addr_sel, mem_we}, 0);
        check("mem_rst_fmt", inst_format, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mem_rst_refetch", {mem_req, mem_addr_sel}, 2'b10);
        fetch(c_ADD, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
